bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side controller for the dual-port sample BRAM. Drains a block of captured samples from one RAM port and emits them as a valid/ready stream toward the readout/serializer path.
- Takes a start address and a word count, issues pipelined reads that match the RAM's fixed read latency, and buffers the returned words in a small credit-controlled FIFO so back-pressure never loses data.

Parameters:
- RAM_WIDTH, 16, sample word width; must match the RAM's data width.
- ADDR_WIDTH, 10, RAM address width (RAM_DEPTH = 2**ADDR_WIDTH).
- RD_LATENCY, 2, cycles from RAM_ADDR/RAM_EN to valid RAM_DOUT. Use 2 for the registered-output RAM and 1 for the low-latency RAM.
- FIFO_DEPTH, 4, output skid FIFO entries; must be >= RD_LATENCY+1; power of two.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- START_ADDR  in  ADDR_WIDTH  first RAM address to read.
- LENGTH  in  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse when the block completes.
- RAM_ADDR  out  ADDR_WIDTH  read address to the RAM port.
- RAM_EN  out  1  RAM port enable; RAM write enable is tied 0 by the parent.
- RAM_DOUT  in  RAM_WIDTH  read data from the RAM port.
- M_DATA  out  RAM_WIDTH  stream data.
- M_VALID  out  1  stream valid.
- M_READY  in  1  stream ready.
- M_LAST  out  1  high with the final word of the block.

Behaviour:
- Reset (async, RST_N=0): state IDLE, FIFO and in-flight pipe cleared. BUSY, DONE, M_VALID, M_LAST, RAM_EN = 0; RAM_ADDR, M_DATA = 0.
- States:
  - IDLE: START=1 and LENGTH>0 -> ISSUE; latch address, remaining-issue count = LENGTH, remaining-output count = LENGTH.
  - IDLE: START=1 and LENGTH=0 -> DONE pulses the next cycle, BUSY stays 0, no reads issued.
  - ISSUE -> DRAIN when the last read is issued.
  - DRAIN -> IDLE on the handshake of the M_LAST word; DONE pulses the following cycle and BUSY falls in the same cycle.
- RAM_EN = 1 in ISSUE and DRAIN, 0 in IDLE, so the RAM output register advances every cycle and the latency is exactly RD_LATENCY.
- Read issue in ISSUE:
  - Issue one read per cycle when (fifo_count + in_flight) < FIFO_DEPTH.
  - A valid-tag shift register of length RD_LATENCY tracks in-flight reads.
  - On each issue, RAM_ADDR increments modulo 2**ADDR_WIDTH; 0x3FF wraps to 0x000.
- Capture: when a tag emerges, RAM_DOUT is written into the FIFO that cycle. The credit rule guarantees the FIFO is never full at that point; overflow is impossible by construction.
- Output: M_VALID = FIFO non-empty; M_DATA is the FIFO head and stays stable while M_VALID=1 and M_READY=0. A word pops on M_VALID & M_READY. M_LAST is asserted when the head is word LENGTH-1.
- Latency: START sampled at cycle 0 -> first RAM_ADDR at cycle 1 -> first M_VALID at cycle 1+RD_LATENCY+1.
  - With M_READY held 1, throughput is 1 word/cycle; a block of N words completes its last handshake at cycle RD_LATENCY+1+N.
- Simultaneous FIFO push and pop in the same cycle: count unchanged, both take effect.
- START while BUSY: ignored; the latched parameters do not change.
- LENGTH = 2**ADDR_WIDTH: every address is read once, and the end address equals START_ADDR after wrap.
- Reset mid-block: immediate return to IDLE, no DONE pulse, in-flight returns discarded.

Optional Feature:
- Macro RAM_READER_ABORT_EN. When defined, adds input ABORT (1 bit) and output ABORTED (1 bit, valid with DONE).
  - ABORT=1 in ISSUE or DRAIN: stop issuing, flush the FIFO (M_VALID=0 the next cycle), and enter FLUSH for RD_LATENCY cycles, discarding returning data.
  - After FLUSH: go to IDLE with DONE=1 and ABORTED=1 for one cycle. ABORT in IDLE has no effect.
- Undefined: no ABORT/ABORTED ports and no FLUSH state. A block always runs to completion or reset.

Test Plan:
- RAM preloaded with data = address; START_ADDR=0x010, LENGTH=8, M_READY=1 -> M_DATA 0x0010..0x0017 on consecutive cycles; first M_VALID at cycle 4 after START with RD_LATENCY=2; M_LAST only on 0x0017; DONE one cycle after.
- Back-pressure: LENGTH=16, M_READY toggling 1/0 plus a stall of 10 cycles -> all 16 words delivered in order with none lost or duplicated. M_DATA is stable while stalled, and (fifo_count + in_flight) never exceeds 4.
- Wrap: START_ADDR=0x3FE, LENGTH=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 and data to match.
- LENGTH=0 -> DONE pulse the next cycle, RAM_EN never asserted, M_VALID never asserted. START pulsed while BUSY during a LENGTH=8 block -> ignored, exactly 8 words out.
- Reset mid-block: assert RST_N=0 after 3 words of a LENGTH=8 block -> all outputs 0 asynchronously. A new START after release gives a clean block from its own START_ADDR.
- With RAM_READER_ABORT_EN: ABORT after 2 words of a LENGTH=8 block -> M_VALID=0 the next cycle, DONE=ABORTED=1 after RD_LATENCY+1 cycles, and no further words.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Read-side controller for the dual-port sample BRAM.
// Drains LENGTH words starting at START_ADDR through a fixed-latency RAM read
// pipeline into a credit-controlled skid FIFO, presented as a valid/ready stream.
// Optional feature: define RAM_READER_ABORT_EN to add ABORT/ABORTED and a FLUSH state.
module bram_stream_reader #(
    parameter int RAM_WIDTH  = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] START_ADDR,
    input  logic [ADDR_WIDTH:0]   LENGTH,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic                  RAM_EN,
    input  logic [RAM_WIDTH-1:0]  RAM_DOUT,
    output logic [RAM_WIDTH-1:0]  M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic                  M_LAST
`ifdef RAM_READER_ABORT_EN
    ,
    input  logic                  ABORT,
    output logic                  ABORTED
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
    localparam logic [PW:0]           FCNT_ONE = (PW+1)'(1);
    localparam logic [CW-1:0]         OCC_MAX  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
`ifdef RAM_READER_ABORT_EN
        ,
        S_FLUSH
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]   out_cnt_q, out_cnt_d;
    logic [RD_LATENCY-1:0] tag_q, tag_d;
    logic [RAM_WIDTH-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           fifo_cnt_q, fifo_cnt_d;
    logic                  done_q, done_d;

    logic [CW-1:0]         inflight;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  fifo_nonempty;
    logic                  last_hs;
    logic                  abort_req;

`ifdef RAM_READER_ABORT_EN
    localparam int FW = $clog2(RD_LATENCY + 1);
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          aborted_q, aborted_d;

    assign abort_req = ABORT && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    assign ABORTED   = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // Credit check: words buffered plus reads still in the RAM pipe must fit the FIFO.
    always_comb begin
        inflight      = CW'($countones(tag_q));
        credit_ok     = (CW'(fifo_cnt_q) + inflight) < OCC_MAX;
        issue         = (state_q == S_ISSUE) && credit_ok && !abort_req;
        push          = tag_q[RD_LATENCY-1];
        fifo_nonempty = (fifo_cnt_q != '0);
        pop           = fifo_nonempty && M_READY;
        last_hs       = pop && (out_cnt_q == CNT_ONE);
    end

    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;
    assign RAM_ADDR = addr_q;
    assign RAM_EN   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign M_DATA   = fifo_mem_q[rd_ptr_q];
    assign M_VALID  = fifo_nonempty;
    assign M_LAST   = fifo_nonempty && (out_cnt_q == CNT_ONE);

    // Next-state logic for the controller, read pipe tags and FIFO pointers.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        tag_d       = (tag_q << 1) | RD_LATENCY'(issue);
        wr_ptr_d    = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        done_d      = 1'b0;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
`ifdef RAM_READER_ABORT_EN
        flush_cnt_d = flush_cnt_q;
        aborted_d   = 1'b0;
`endif

        if (pop) begin
            out_cnt_d = out_cnt_q - CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (LENGTH != '0) begin
                        state_d     = S_ISSUE;
                        addr_d      = START_ADDR;
                        issue_cnt_d = LENGTH;
                        out_cnt_d   = LENGTH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_ONE;
                    issue_cnt_d = issue_cnt_q - CNT_ONE;
                    if (issue_cnt_q == CNT_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (last_hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef RAM_READER_ABORT_EN
            S_FLUSH: begin
                flush_cnt_d = flush_cnt_q - FW'(1);
                if (flush_cnt_q == FW'(1)) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef RAM_READER_ABORT_EN
        // Abort clears the tags too, so reads already in the RAM pipe are dropped on return.
        if (abort_req) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FW'(RD_LATENCY);
            tag_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fifo_cnt_d  = '0;
        end
`endif
    end

    // Controller, pipe and pointer registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            done_q      <= 1'b0;
`ifdef RAM_READER_ABORT_EN
            flush_cnt_q <= '0;
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            done_q      <= done_d;
`ifdef RAM_READER_ABORT_EN
            flush_cnt_q <= flush_cnt_d;
            aborted_q   <= aborted_d;
`endif
        end
    end

    // FIFO storage: capture RAM_DOUT when a read tag emerges from the pipe.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_mem_q <= '{default: '0};
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= RAM_DOUT;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 2-cycle registered RAM model holding data = address.
module tb_bram_stream_reader;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [9:0]  START_ADDR;
    logic [10:0] LENGTH;
    logic        BUSY;
    logic        DONE;
    logic [9:0]  RAM_ADDR;
    logic        RAM_EN;
    logic [15:0] RAM_DOUT;
    logic [15:0] M_DATA;
    logic        M_VALID;
    logic        M_READY;
    logic        M_LAST;
`ifdef RAM_READER_ABORT_EN
    logic        ABORT;
    logic        ABORTED;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    // RAM model: registered output, two cycles from address to data.
    logic [15:0] ram_s1 = '0;
    logic [15:0] ram_s2 = '0;
    always_ff @(posedge CLK) begin
        if (RAM_EN) begin
            ram_s1 <= {6'd0, RAM_ADDR};
            ram_s2 <= ram_s1;
        end
    end
    assign RAM_DOUT = ram_s2;

    bram_stream_reader #(
        .RAM_WIDTH (16),
        .ADDR_WIDTH(10),
        .RD_LATENCY(2),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .START_ADDR(START_ADDR),
        .LENGTH    (LENGTH),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_EN    (RAM_EN),
        .RAM_DOUT  (RAM_DOUT),
        .M_DATA    (M_DATA),
        .M_VALID   (M_VALID),
        .M_READY   (M_READY),
        .M_LAST    (M_LAST)
`ifdef RAM_READER_ABORT_EN
        ,
        .ABORT     (ABORT),
        .ABORTED   (ABORTED)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: ready always high; mode 1: ready toggles with a 10-cycle stall;
    // mode 2: ready high, extra START pulse with different parameters mid-block.
    task automatic run_block(input logic [9:0] sa, input logic [10:0] len, input int mode,
                             input int budget, output int first_v, output int done_cyc,
                             output int nwords);
        int          cyc;
        int          idx;
        int          last_cyc;
        logic        stalled;
        logic [15:0] held;
        START      = 1'b1;
        START_ADDR = sa;
        LENGTH     = len;
        M_READY    = (mode != 1);
        step();
        START    = 1'b0;
        cyc      = 1;
        idx      = 0;
        last_cyc = -1;
        first_v  = -1;
        done_cyc = -1;
        stalled  = 1'b0;
        held     = '0;
        check("first_addr", 32'(RAM_ADDR), 32'(sa));
        check("busy_en", 32'({BUSY, RAM_EN}), 32'd3);
        while (cyc <= budget && done_cyc < 0) begin
            if (mode == 1) M_READY = (cyc >= 8 && cyc < 18) ? 1'b0 : (cyc % 2 == 1);
            else           M_READY = 1'b1;
            if (mode == 2) begin
                START      = (cyc == 3);
                START_ADDR = 10'h200;
                LENGTH     = 11'd3;
            end
            #1;
            if (M_VALID && first_v < 0) first_v = cyc;
            if (stalled) begin
                check("stall_valid", 32'(M_VALID), 32'd1);
                check("stall_data", 32'(M_DATA), 32'(held));
            end
            if (DONE) begin
                done_cyc = cyc;
                check("busy_at_done", 32'(BUSY), 32'd0);
                check("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
            end
            if (M_VALID && M_READY) begin
                check("data", 32'(M_DATA), 32'((int'(sa) + idx) % 1024));
                check("last", 32'(M_LAST), 32'(idx == int'(len) - 1));
                idx++;
                if (idx == int'(len)) last_cyc = cyc;
            end
            stalled = M_VALID && !M_READY;
            held    = M_DATA;
            step();
            cyc++;
        end
        START  = 1'b0;
        nwords = idx;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   fv, dc, nw, hs;
        logic seen;
        RST_N      = 1'b0;
        START      = 1'b0;
        START_ADDR = '0;
        LENGTH     = '0;
        M_READY    = 1'b0;
`ifdef RAM_READER_ABORT_EN
        ABORT      = 1'b0;
`endif
        repeat (2) step();
        check("rst_ctrl", 32'({BUSY, DONE, M_VALID, M_LAST, RAM_EN}), 32'd0);
        check("rst_addr", 32'(RAM_ADDR), 32'd0);
        check("rst_data", 32'(M_DATA), 32'd0);
        RST_N = 1'b1;
        step();

        // Basic block with ready held high.
        run_block(10'h010, 11'd8, 0, 40, fv, dc, nw);
        check("basic_first_valid", 32'(fv), 32'd4);
        check("basic_done_cyc", 32'(dc), 32'd12);
        check("basic_words", 32'(nw), 32'd8);

        // Back-pressure.
        run_block(10'h020, 11'd16, 1, 150, fv, dc, nw);
        check("bp_words", 32'(nw), 32'd16);
        check("bp_first_valid", 32'(fv), 32'd4);

        // Address wrap.
        run_block(10'h3FE, 11'd4, 0, 40, fv, dc, nw);
        check("wrap_words", 32'(nw), 32'd4);
        check("wrap_done_cyc", 32'(dc), 32'd8);

        // Zero length.
        START  = 1'b1;
        LENGTH = 11'd0;
        START_ADDR = 10'h111;
        step();
        START = 1'b0;
        check("zero_done", 32'({DONE, BUSY}), 32'd2);
        seen = RAM_EN | M_VALID;
        step();
        check("zero_done_pulse", 32'(DONE), 32'd0);
        repeat (4) begin
            seen = seen | RAM_EN | M_VALID;
            step();
        end
        check("zero_no_activity", 32'(seen), 32'd0);

        // START while busy is ignored.
        run_block(10'h040, 11'd8, 2, 40, fv, dc, nw);
        check("busy_start_words", 32'(nw), 32'd8);
        check("busy_start_done", 32'(dc), 32'd12);
        step();
        check("busy_start_idle", 32'({BUSY, RAM_EN}), 32'd0);

        // Reset in the middle of a block.
        START      = 1'b1;
        START_ADDR = 10'h080;
        LENGTH     = 11'd8;
        M_READY    = 1'b1;
        step();
        START = 1'b0;
        hs    = 0;
        for (int c = 0; c < 30 && hs < 3; c++) begin
            if (M_VALID && M_READY) hs++;
            step();
        end
        check("rst_mid_words", 32'(hs), 32'd3);
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'({BUSY, DONE, M_VALID, M_LAST, RAM_EN}), 32'd0);
        check("rst_mid_addr", 32'(RAM_ADDR), 32'd0);
        check("rst_mid_data", 32'(M_DATA), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        seen = 1'b0;
        repeat (4) begin
            seen = seen | DONE | M_VALID | BUSY;
            step();
        end
        check("rst_mid_quiet", 32'(seen), 32'd0);
        run_block(10'h150, 11'd5, 0, 30, fv, dc, nw);
        check("post_rst_words", 32'(nw), 32'd5);
        check("post_rst_done", 32'(dc), 32'd9);

        // Full address space.
        run_block(10'h155, 11'd1024, 0, 1100, fv, dc, nw);
        check("full_words", 32'(nw), 32'd1024);
        check("full_done", 32'(dc), 32'd1028);
        check("full_end_addr", 32'(RAM_ADDR), 32'h155);

`ifdef RAM_READER_ABORT_EN
        // Abort after two words.
        START      = 1'b1;
        START_ADDR = 10'h0A0;
        LENGTH     = 11'd8;
        M_READY    = 1'b1;
        step();
        START = 1'b0;
        hs    = 0;
        for (int c = 0; c < 30 && hs < 2; c++) begin
            if (M_VALID && M_READY) hs++;
            step();
        end
        check("abort_pre_words", 32'(hs), 32'd2);
        M_READY = 1'b0;
        ABORT   = 1'b1;
        step();
        ABORT   = 1'b0;
        M_READY = 1'b1;
        #1;
        check("abort_flush_valid", 32'({M_VALID, DONE}), 32'd0);
        step();
        check("abort_wait", 32'({M_VALID, DONE}), 32'd0);
        step();
        check("abort_done", 32'({DONE, ABORTED, BUSY}), 32'd6);
        seen = 1'b0;
        repeat (4) begin
            seen = seen | M_VALID;
            step();
        end
        check("abort_no_words", 32'(seen), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
